// File: rtl/msrv32_dmem_responder_if.sv
// Purpose : bus bundle between the msrv32 store path (master) and the data-memory responder (slave).
// Latency : n/a (wires only).
// Backpressure: ready_out low stalls the master's address phase; resp_err_out flags an errored transfer.
// Signals:
//   d_addr_in, htrans_in, wr_req_in, wr_mask_in : address phase, driven by master
//   data_in                                     : write data, data phase, driven by master
//   ready_out, resp_err_out, rdata_out          : response, driven by slave
interface msrv32_dmem_responder_if;
    logic [31:0] d_addr_in;
    logic [1:0]  htrans_in;
    logic        wr_req_in;
    logic [3:0]  wr_mask_in;
    logic [31:0] data_in;
    logic        ready_out;
    logic        resp_err_out;
    logic [31:0] rdata_out;

    modport master (
        output d_addr_in, htrans_in, wr_req_in, wr_mask_in, data_in,
        input  ready_out, resp_err_out, rdata_out
    );

    modport slave (
        input  d_addr_in, htrans_in, wr_req_in, wr_mask_in, data_in,
        output ready_out, resp_err_out, rdata_out
    );
endinterface

// File: rtl/msrv32_dmem_responder.sv
// Purpose : AHB-lite-style data-memory responder: masked byte-lane writes, word reads, error on out-of-range.
// Latency : data phase of WAIT_STATES+1 cycles per in-range transfer, 2 cycles for an errored transfer.
// Backpressure: ready_out held low during wait states and the first error cycle; address phase sampled only when high.
// Ports:
//   clk_in   : clock, rising edge
//   rst_n_in : asynchronous active-low reset
//   bus      : slave side of msrv32_dmem_responder_if (address/data phase in, ready/resp/rdata out)
module msrv32_dmem_responder #(
    parameter int          DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    msrv32_dmem_responder_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_ERR1 = 2'd2,
        S_ERR2 = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            wr_q, wr_d;
    logic [3:0]      mask_q, mask_d;

    // Word array; contents deliberately survive reset.
    logic [31:0]     mem [DEPTH];

    logic [31:0]     addr_off;
    logic            trans_vld;
    logic            in_range;
    logic            ready;
    logic            commit;

    // Unsigned wrap-around makes addresses below BASE_ADDR land far out of range.
    assign addr_off = bus.d_addr_in - BASE_ADDR;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        wr_d      = wr_q;
        mask_d    = mask_q;
        ready     = 1'b0;
        commit    = 1'b0;
        trans_vld = (bus.htrans_in == 2'b10) || (bus.htrans_in == 2'b11);
        in_range  = (addr_off >> 2) < 32'(DEPTH);

        case (state_q)
            S_IDLE: ready = 1'b1;
            S_DATA: begin
                if (cnt_q != 3'd0) begin
                    cnt_d = cnt_q - 3'd1;
                end else begin
                    ready  = 1'b1;
                    commit = 1'b1;
                end
            end
            S_ERR1: state_d = S_ERR2;
            S_ERR2: ready = 1'b1;
            default: state_d = S_IDLE;
        endcase

        // Every ready-high cycle is also the next transfer's address phase.
        if (ready) begin
            if (trans_vld && in_range) begin
                state_d = S_DATA;
                cnt_d   = 3'(WAIT_STATES);
                idx_d   = addr_off[AW+1:2];
                wr_d    = bus.wr_req_in;
                mask_d  = bus.wr_mask_in;
            end else if (trans_vld) begin
                state_d = S_ERR1;
            end else begin
                state_d = S_IDLE;
            end
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            mask_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            wr_q    <= wr_d;
            mask_q  <= mask_d;
        end
    end

    // Write data is taken only on the committing edge; reset forces S_IDLE so a pending write is dropped.
    always_ff @(posedge clk_in) begin
        if (commit && wr_q) begin
            for (int i = 0; i < 4; i++) begin
                if (mask_q[i]) begin
                    mem[idx_q][8*i +: 8] <= bus.data_in[8*i +: 8];
                end
            end
        end
    end

    assign bus.ready_out    = ready;
    assign bus.resp_err_out = (state_q == S_ERR1) || (state_q == S_ERR2);
    assign bus.rdata_out    = (commit && !wr_q) ? mem[idx_q] : 32'd0;
endmodule
